// File: rtl/hdmi_tx_link_ctrl.sv
// TMDS link bring-up sequencer: serializer reset, filtered PLL lock, control-token
// settle period, then video pass-through; loss of lock returns the link to reset.
module hdmi_tx_link_ctrl #(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_FILT     = 64,
  parameter int unsigned LOCK_TIMEOUT  = 262144,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter logic [9:0]  CTRL_SYMBOL   = 10'b1101010100,
  parameter logic [9:0]  CLK_PATTERN   = 10'b0000011111
) (
  input  logic             clk_pixel,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic             video_en,
  input  logic [2:0][9:0]  tmds_vid_in,
  output logic [3:0][9:0]  tmds_par_out,
  output logic             ser_reset,
  output logic             link_ready,
  output logic [1:0]       link_state,
  output logic [7:0]       relock_count
);

  localparam logic [1:0] ST_HOLD   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_ACTIVE = 2'd3;

  localparam logic [19:0] RC_LAST = 20'(RESET_CYCLES - 1);
  localparam logic [19:0] LF_LAST = 20'(LOCK_FILT - 1);
  localparam logic [19:0] LT_LAST = 20'(LOCK_TIMEOUT - 1);
  localparam logic [19:0] SC_LAST = 20'(SETTLE_CYCLES - 1);

  logic             r_sync1;
  logic             r_lock_s;
  logic [1:0]       r_state;
  logic [19:0]      r_cnt;
  logic [19:0]      r_tmo;
  logic [7:0]       r_relock;
  logic [3:0][9:0]  r_par;

  logic [1:0]       w_state_nxt;
  logic [19:0]      w_cnt_nxt;
  logic [19:0]      w_tmo_nxt;
  logic             w_relock_inc;
  logic             w_pass;
  logic [3:0][9:0]  w_par_nxt;

  // Two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= pll_locked;
      r_lock_s <= r_sync1;
    end
  end

  // Next-state and counter logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_tmo_nxt    = r_tmo;
    w_relock_inc = 1'b0;
    case (r_state)
      ST_HOLD: begin
        if (r_cnt == RC_LAST) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = 20'd0;
          w_tmo_nxt   = 20'd0;
        end else begin
          w_cnt_nxt = r_cnt + 20'd1;
        end
      end
      ST_WAIT: begin
        w_tmo_nxt = r_tmo + 20'd1;
        if (r_lock_s && (r_cnt == LF_LAST)) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = 20'd0;
          w_tmo_nxt   = 20'd0;
        end else if (r_tmo == LT_LAST) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = 20'd0;
          w_tmo_nxt   = 20'd0;
        end else if (r_lock_s) begin
          w_cnt_nxt = r_cnt + 20'd1;
        end else begin
          w_cnt_nxt = 20'd0;
        end
      end
      ST_SETTLE: begin
        if (!r_lock_s) begin
          w_state_nxt  = ST_HOLD;
          w_cnt_nxt    = 20'd0;
          w_tmo_nxt    = 20'd0;
          w_relock_inc = 1'b1;
        end else if (r_cnt == SC_LAST) begin
          w_state_nxt = ST_ACTIVE;
          w_cnt_nxt   = 20'd0;
        end else begin
          w_cnt_nxt = r_cnt + 20'd1;
        end
      end
      ST_ACTIVE: begin
        if (!r_lock_s) begin
          w_state_nxt  = ST_HOLD;
          w_cnt_nxt    = 20'd0;
          w_tmo_nxt    = 20'd0;
          w_relock_inc = 1'b1;
        end else begin
          w_state_nxt = ST_ACTIVE;
        end
      end
      default: begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = 20'd0;
        w_tmo_nxt   = 20'd0;
      end
    endcase
  end

  // Gating on lock_s too makes the lanes fall back to control tokens on the
  // same edge that leaves ACTIVE, not one cycle later.
  always_comb begin
    w_pass    = (r_state == ST_ACTIVE) && r_lock_s && video_en;
    w_par_nxt = {CLK_PATTERN, CTRL_SYMBOL, CTRL_SYMBOL, CTRL_SYMBOL};
    if (w_pass) begin
      w_par_nxt[2:0] = tmds_vid_in;
    end else begin
      w_par_nxt[2:0] = {CTRL_SYMBOL, CTRL_SYMBOL, CTRL_SYMBOL};
    end
  end

  // State, counters, relock counter and lane registers
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_HOLD;
      r_cnt    <= 20'd0;
      r_tmo    <= 20'd0;
      r_relock <= 8'd0;
      r_par    <= {CLK_PATTERN, CTRL_SYMBOL, CTRL_SYMBOL, CTRL_SYMBOL};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tmo   <= w_tmo_nxt;
      r_par   <= w_par_nxt;
      if (w_relock_inc && (r_relock != 8'hFF)) begin
        r_relock <= r_relock + 8'd1;
      end else begin
        r_relock <= r_relock;
      end
    end
  end

  assign tmds_par_out = r_par;
  assign link_state   = r_state;
  assign ser_reset    = (r_state == ST_HOLD);
  assign link_ready   = (r_state == ST_ACTIVE);
  assign relock_count = r_relock;

endmodule
